// File: rtl/matrix_instruction_issuer.sv
// matrix_instruction_issuer
//
// HPS-side initiator for the matrix coprocessor's 32-bit instruction port.
// A single command is serialised as packets in this order:
//   13 store packets for matrix A (opcode 7)
//   13 store packets for matrix B (opcode 8, only for opcodes 0..3)
//   one operation packet
//   7 load packets (opcode 9), or just one for determinant (opcode 4)
// The load data is reassembled into a 200-bit result.
//
// Every packet is held with start=1 for at least MIN_HOLD cycles.
// It completes once coproc_ready is also high.
// Packets are separated by GAP_CYCLES cycles in which instruction is 0.
// A packet still waiting after TIMEOUT cycles aborts the command with an error.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   cmd_*             command handshake and fields (opcode, size code, matrices A/B)
//   instruction       packet word driven to the coprocessor
//   coproc_ready      coprocessor completion level
//   coproc_data       coprocessor read data
//   coproc_overflow   coprocessor overflow flag
//   result_*          result handshake, reassembled matrix, overflow and error flags
//   busy              high from command acceptance until the result is consumed

module matrix_instruction_issuer #(
  parameter int MIN_HOLD   = 5,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [3:0]   cmd_opcode,
  input  logic [1:0]   cmd_msize,
  input  logic [199:0] cmd_matrix_a,
  input  logic [199:0] cmd_matrix_b,
  output logic [31:0]  instruction,
  input  logic         coproc_ready,
  input  logic [31:0]  coproc_data,
  input  logic         coproc_overflow,
  output logic         result_valid,
  input  logic         result_ready,
  output logic [199:0] result_matrix,
  output logic         result_overflow,
  output logic         result_error,
  output logic         busy
);

  localparam int CW = $clog2(TIMEOUT + MIN_HOLD + GAP_CYCLES + 1);

  localparam logic [3:0] OP_STORE_A = 4'd7;
  localparam logic [3:0] OP_STORE_B = 4'd8;
  localparam logic [3:0] OP_LOAD    = 4'd9;
  localparam logic [3:0] OP_DET     = 4'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_STORE_A,
    S_STORE_B,
    S_OPERATE,
    S_LOAD,
    S_RESPOND
  } state_t;

  typedef enum logic {
    PH_ISSUE,
    PH_GAP
  } phase_t;

  state_t state, state_next, after_state;
  phase_t phase, phase_next;

  logic [3:0]    pos;
  logic [CW-1:0] hold_cnt;
  logic [CW-1:0] gap_cnt;
  logic [3:0]    opcode_q;
  logic [1:0]    msize_q;
  logic [199:0]  matrix_a_q;
  logic [199:0]  matrix_b_q;
  logic [199:0]  result_q;
  logic          overflow_q;
  logic          error_q;

  logic          accept;
  logic          in_packet_state;
  logic          issuing;
  logic          complete;
  logic          timed_out;
  logic          gap_done;
  logic          last_pos;
  logic [3:0]    pkt_opcode;
  logic [15:0]   pkt_data;
  logic [199:0]  store_src;
  logic [199:0]  load_bits;
  logic [199:0]  load_mask;

  // hold_cnt counts the cycles already spent on the current packet.
  // "At least MIN_HOLD cycles held" therefore means hold_cnt >= MIN_HOLD-1
  // in the cycle being considered.
  always_comb begin
    in_packet_state = (state == S_STORE_A) || (state == S_STORE_B) ||
                      (state == S_OPERATE) || (state == S_LOAD);
    issuing   = in_packet_state && (phase == PH_ISSUE);
    complete  = issuing && coproc_ready && (hold_cnt >= CW'(MIN_HOLD - 1));
    timed_out = issuing && !complete && (hold_cnt >= CW'(TIMEOUT - 1));
    gap_done  = in_packet_state && (phase == PH_GAP) && (gap_cnt >= CW'(GAP_CYCLES - 1));
    accept    = (state == S_IDLE) && cmd_valid;
  end

  // Last position of each packet group, and the group that follows it.
  always_comb begin
    last_pos    = 1'b0;
    after_state = state;
    case (state)
      S_STORE_A: begin
        last_pos    = (pos == 4'd12);
        after_state = (opcode_q <= 4'd3) ? S_STORE_B : S_OPERATE;
      end
      S_STORE_B: begin
        last_pos    = (pos == 4'd12);
        after_state = S_OPERATE;
      end
      S_OPERATE: begin
        last_pos    = 1'b1;
        after_state = S_LOAD;
      end
      S_LOAD: begin
        last_pos    = (opcode_q == OP_DET) ? (pos == 4'd0) : (pos == 4'd6);
        after_state = S_RESPOND;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_next = state;
    phase_next = phase;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          state_next = (cmd_opcode >= 4'd7) ? S_RESPOND : S_STORE_A;
          phase_next = PH_ISSUE;
        end
      end
      S_RESPOND: begin
        if (result_ready) begin
          state_next = S_IDLE;
          phase_next = PH_ISSUE;
        end
      end
      default: begin
        if (timed_out) begin
          state_next = S_RESPOND;
          phase_next = PH_ISSUE;
        end else if (complete) begin
          if (last_pos) begin
            state_next = after_state;
          end
          // The final load packet goes straight to RESPOND without a gap.
          phase_next = (last_pos && (after_state == S_RESPOND)) ? PH_ISSUE : PH_GAP;
        end else if (gap_done) begin
          phase_next = PH_ISSUE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      phase <= PH_ISSUE;
    end else begin
      state <= state_next;
      phase <= phase_next;
    end
  end

  // Store position p carries elements 2p and 2p+1.
  // Position 12 only has element 24, so its low byte is padded with zero.
  // Load position p lands at result bits [199-32p -: 32].
  // For position 6 the shift leaves only coproc_data[31:24], which lands in [7:0].
  always_comb begin
    store_src = (state == S_STORE_B) ? matrix_b_q : matrix_a_q;
    pkt_data  = {store_src[7:0], 8'h00};
    for (int k = 0; k < 12; k++) begin
      if (pos == 4'(k)) begin
        pkt_data = store_src[199-16*k -: 16];
      end
    end
    if (!((state == S_STORE_A) || (state == S_STORE_B))) begin
      pkt_data = 16'h0000;
    end

    case (state)
      S_STORE_A: pkt_opcode = OP_STORE_A;
      S_STORE_B: pkt_opcode = OP_STORE_B;
      S_LOAD:    pkt_opcode = OP_LOAD;
      default:   pkt_opcode = opcode_q;
    endcase

    load_bits = {coproc_data, 168'h0} >> {pos[2:0], 5'b00000};
    load_mask = {32'hFFFF_FFFF, 168'h0} >> {pos[2:0], 5'b00000};

    instruction     = issuing ? {5'b00000, pkt_data, pkt_opcode, msize_q, pos, 1'b1} : 32'h0;
    cmd_ready       = (state == S_IDLE);
    busy            = (state != S_IDLE);
    result_valid    = (state == S_RESPOND);
    result_matrix   = result_q;
    result_overflow = overflow_q;
    result_error    = error_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pos        <= '0;
      hold_cnt   <= '0;
      gap_cnt    <= '0;
      opcode_q   <= '0;
      msize_q    <= '0;
      matrix_a_q <= '0;
      matrix_b_q <= '0;
      result_q   <= '0;
      overflow_q <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      hold_cnt <= (issuing && !complete && !timed_out) ? hold_cnt + CW'(1) : '0;
      gap_cnt  <= (in_packet_state && (phase == PH_GAP) && !gap_done) ? gap_cnt + CW'(1) : '0;
      if (accept) begin
        pos        <= '0;
        opcode_q   <= cmd_opcode;
        msize_q    <= cmd_msize;
        matrix_a_q <= cmd_matrix_a;
        matrix_b_q <= cmd_matrix_b;
        result_q   <= '0;
        overflow_q <= 1'b0;
        error_q    <= (cmd_opcode >= 4'd7);
      end else begin
        if (complete) begin
          pos <= last_pos ? 4'd0 : pos + 4'd1;
        end
        if (complete && (state == S_OPERATE)) begin
          overflow_q <= coproc_overflow;
        end
        // Merge load data in the same cycle the packet completes.
        if (complete && (state == S_LOAD)) begin
          result_q <= (result_q & ~load_mask) | (load_bits & load_mask);
        end
        if (timed_out) begin
          error_q <= 1'b1;
        end
      end
    end
  end

endmodule
